uart_rx_ctrl: RTL and testbench

UART receive controller: the receiving counterpart of the team's transmit FSM. Oversamples the serial line `RX_IN` by a runtime `PRESCALE`, detects and qualifies the start bit, and deserializes LSB-first data. It then checks optional parity and the stop bit, and delivers parallel data with a one-cycle `DATA_VALID` strobe. It sits between the synchronized RX pad and the system's RX data consumer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 65 ++++++
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity constants shared by the UART RX and TX controllers.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling in uart_rx_sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 2-of-3 vote used by the oversampling majority filter
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and mid-bit sampling of the RX line.
// Build option: UART_RX_MAJORITY_EN defined -> 2-of-3 vote over edges P/2-1, P/2, P/2+1;
// undefined -> single sample at P/2. Either way the decision is presented at P/2+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  s_mid;

  assign half = prescale >> 1;
  assign last = prescale - PRESCALE_W'(1);

  // Edge counter: 0..P-1 within a bit, held at 0 while the receiver is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (!en || (edge_cnt == last)) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  // Mid-bit sample; reset to the idle line level
  always_ff @(posedge clk) begin
    if (rst) begin
      s_mid <= 1'b1;
    end else if (en && (edge_cnt == half)) begin
      s_mid <= rx_in;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_early;

  // Early sample one edge before mid-bit; the late sample is the live line at the decision edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s_early <= 1'b1;
    end else if (en && (edge_cnt == (half - PRESCALE_W'(1)))) begin
      s_early <= rx_in;
    end
  end

  assign sampled_bit = maj3(s_early, s_mid, rx_in);
`else
  assign sampled_bit = s_mid;
`endif

  assign sample_done = en && (edge_cnt == (half + PRESCALE_W'(1)));

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM - start qualification, LSB-first deserialization,
// optional parity and stop checks, registered parallel output with a one-cycle valid strobe.
// Build option: UART_RX_MAJORITY_EN (forwarded to uart_rx_sampler) enables majority sampling.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  bit_q;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  last_edge;
  logic                  sampler_en;
  logic                  par_exp;

  assign sampler_en = (state != IDLE);
  assign last_edge  = (edge_cnt == (prescale_q - PRESCALE_W'(1)));
  assign par_exp    = (par_typ_q == PAR_EVEN) ? (^shift_reg) : ~(^shift_reg);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .rx_in       (RX_IN),
    .en          (sampler_en),
    .prescale    (prescale_q),
    .edge_cnt    (edge_cnt),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  // Frame FSM with bit counter, shift register, error checks and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_q      <= 1'b1;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!RX_IN) begin
            state      <= START;
            prescale_q <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
          end
        end
        START: begin
          // Flags of a frame followed back-to-back stay visible until this start bit is judged
          if (sample_done) begin
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
          end
          if (sample_done && sampled_bit) begin
            state <= IDLE;
          end else if (last_edge) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (sample_done) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          end
          if (last_edge) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (sample_done) begin
            bit_q <= sampled_bit;
          end
          if (last_edge) begin
            if (bit_q != par_exp) begin
              PAR_ERR <= 1'b1;
            end
            state <= STOP;
          end
        end
        STOP: begin
          if (sample_done) begin
            bit_q <= sampled_bit;
          end
          if (last_edge) begin
            if (!bit_q) begin
              STP_ERR <= 1'b1;
            end else if (!PAR_ERR) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shift_reg;
            end
            if (!RX_IN) begin
              state      <= START;
              prescale_q <= PRESCALE;
              par_en_q   <= PAR_EN;
              par_typ_q  <= PAR_TYP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frames against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [DW-1:0] exp_pdata;
  int            vq[$];
  logic [DW-1:0] dq[$];

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with its cycle index and data
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      vq.push_back(cyc);
      dq.push_back(p_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic pe,
                                           input logic pbit, input logic stopv);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (pe) b[9] = pbit;
    b[pe ? 10 : 9] = stopv;
    return b;
  endfunction

  function automatic logic even_par_bit(input logic [7:0] d);
    return (($countones(d) % 2) == 1);
  endfunction

  // Drive the first nk oversample cycles of a frame; optional one-cycle inversion at spike_k
  task automatic drive(input logic [15:0] bits, input int p, input int nk,
                       input int spike_k, output int t);
    logic lv;
    t = cyc;
    for (int k = 0; k < nk; k++) begin
      lv = bits[k / p];
      if (k == spike_k) lv = ~lv;
      rx_in = lv;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int p, input logic pe, input logic typ,
                           input logic pbit, input logic stopv, input int spike_k,
                           input int exp_lat, input string tag);
    int   n;
    int   t;
    logic perr;
    logic good;
    n    = pe ? 11 : 10;
    perr = pe && (pbit != (even_par_bit(d) ^ typ));
    good = stopv && !perr;
    prescale = PW'(p);
    par_en   = pe;
    par_typ  = typ;
    vq.delete();
    dq.delete();
    drive(mk_frame(d, pe, pbit, stopv), p, n * p, spike_k, t);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    if (good) exp_pdata = d;
    chk({tag, "_pulses"}, 32'(vq.size()), good ? 32'd1 : 32'd0);
    if (good && vq.size() > 0) begin
      chk({tag, "_latency"}, 32'(vq[0] - t), 32'(n * p + 1));
      chk({tag, "_pulse_data"}, 32'(dq[0]), 32'(d));
      if (exp_lat != 0) chk({tag, "_abs_latency"}, 32'(vq[0] - t), 32'(exp_lat));
    end
    chk({tag, "_p_data"}, 32'(p_data), 32'(exp_pdata));
    chk({tag, "_par_err"}, 32'(par_err), 32'(perr));
    chk({tag, "_stp_err"}, 32'(stp_err), 32'(!stopv));
  endtask

  initial begin
    int          t1;
    int          t2;
    logic [7:0]  d;
    int          p;
    logic        pe;
    logic        typ;
    logic        pbit;
    logic        stopv;

    rst       = 1'b1;
    rx_in     = 1'b1;
    prescale  = PW'(8);
    par_en    = 1'b0;
    par_typ   = 1'b0;
    exp_pdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_p_data", 32'(p_data), 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_par_err", 32'(par_err), 32'd0);
    chk("reset_stp_err", 32'(stp_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Good 8N1 frame at P=8
    run_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 81, "good_a5");

    // Even parity at P=16: correct then wrong parity bit
    run_frame(8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 177, "par_ok");
    run_frame(8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, "par_bad");

    // Stop bit low for the whole bit; flag must persist while idle
    run_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, "stop_bad");
    repeat (20) @(negedge clk);
    chk("stop_bad_hold", 32'(stp_err), 32'd1);
    run_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, "after_stop_bad");

    // 3-cycle glitch at P=16 must be rejected silently
    prescale = PW'(16);
    vq.delete();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_pulses", 32'(vq.size()), 32'd0);
    chk("glitch_par_err", 32'(par_err), 32'd0);
    chk("glitch_stp_err", 32'(stp_err), 32'd0);
    chk("glitch_p_data", 32'(p_data), 32'(exp_pdata));

    // Spike away from the sampling window inside data bit 2
    run_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1 + 3 * 16 + 1, 0, "spike_edge1");
`ifdef UART_RX_MAJORITY_EN
    // Spike exactly at mid-bit is outvoted
    run_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1 + 3 * 16 + 8, 0, "spike_mid");
`endif

    // Back-to-back frames with no idle gap
    prescale = PW'(8);
    par_en   = 1'b0;
    par_typ  = 1'b0;
    vq.delete();
    dq.delete();
    drive(mk_frame(8'h3C, 1'b0, 1'b0, 1'b1), 8, 80, -1, t1);
    drive(mk_frame(8'hC3, 1'b0, 1'b0, 1'b1), 8, 80, -1, t2);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b_pulses", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      chk("b2b_first_latency", 32'(vq[0] - t1), 32'd81);
      chk("b2b_spacing", 32'(vq[1] - vq[0]), 32'd80);
      chk("b2b_data0", 32'(dq[0]), 32'h3C);
      chk("b2b_data1", 32'(dq[1]), 32'hC3);
    end
    exp_pdata = 8'hC3;
    chk("b2b_p_data", 32'(p_data), 32'(exp_pdata));
    chk("b2b_flags", {30'd0, par_err, stp_err}, 32'd0);

    // Reset during data bit 4, then a fresh frame
    vq.delete();
    drive(mk_frame(8'h96, 1'b0, 1'b0, 1'b1), 8, 44, -1, t1);
    rst   = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pdata = '0;
    chk("midrst_p_data", 32'(p_data), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_flags", {30'd0, par_err, stp_err}, 32'd0);
    repeat (100) @(negedge clk);
    chk("midrst_no_pulse", 32'(vq.size()), 32'd0);
    run_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 81, "post_rst_5a");

    // Randomized frames with occasional parity or stop corruption
    for (int i = 0; i < 12; i++) begin
      d     = 8'($urandom);
      p     = 8 + 2 * int'($urandom_range(0, 12));
      pe    = 1'($urandom_range(0, 1));
      typ   = 1'($urandom_range(0, 1));
      pbit  = even_par_bit(d) ^ typ ^ ($urandom_range(0, 5) == 0);
      stopv = ($urandom_range(0, 7) != 0);
      run_frame(d, p, pe, typ, pbit, stopv, -1, 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
